i2c_bus_scheduler: RTL
======================

// Module: i2c_bus_scheduler
// PURPOSE
//  Shares one IICMB byte-level command port between NUM_REQ requesters (test sequencers, cfg engine).
//  Round-robin ownership is held from grant until release; START..STOP transfers are never interleaved.
//  A watchdog forces STOP if an owner stalls with the bus open. Sits between requesters and the IICMB cmd/rsp adapter.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8)
//  TIMEOUT_CYC  4096  idle cycles with bus open before forced STOP (>=2)
// PORTS
//  clk_i          in   1          clock, rising edge
//  rst_n_i        in   1          async active-low reset
//  req_i          in   NUM_REQ    ownership request, level; held for whole session
//  cmd_valid_i    in   NUM_REQ    per-requester command valid
//  cmd_i          in   3*NUM_REQ  command [3r+:3]: 0 START,1 STOP,2 RD_ACK,3 RD_NAK,4 WRITE,5 SET_BUS,6 WAIT
//  wdata_i        in   8*NUM_REQ  write byte / bus id / wait ms [8r+:8]
//  cmd_ready_o    out  NUM_REQ    command accepted (owner only)
//  grant_o        out  NUM_REQ    one-hot current owner, 0 when idle
//  rsp_valid_o    out  NUM_REQ    1-cycle response pulse to owner
//  rsp_code_o     out  2          0 DONE,1 NAK,2 ARB_LOST,3 ERR
//  rdata_o        out  8          read byte, valid with rsp_valid_o
//  m_cmd_valid_o  out  1          command to IICMB adapter
//  m_cmd_o        out  3          command code
//  m_wdata_o      out  8          command data
//  m_cmd_ready_i  in   1          adapter accepts command
//  m_rsp_valid_i  in   1          adapter response pulse
//  m_rsp_code_i   in   2          response code, same encoding as rsp_code_o
//  m_rdata_i      in   8          read byte
//  busy_o         out  1          owner present or forced STOP in progress
//  timeout_o      out  1          1-cycle pulse on watchdog release
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last_owner=NUM_REQ-1; bus_open=0; watchdog=0. No STOP is issued on reset.
//  FSM IDLE -> OWNED -> WAIT_RSP -> OWNED ...; OWNED -> FORCE_STOP -> FORCE_WAIT -> IDLE.
//  IDLE: any req_i -> owner = first set bit searching upward from last_owner+1 (wrap); grant_o one-hot next cycle.
//  OWNED: m_cmd_valid_o = cmd_valid_i[own] & req_i[own] (combinational); m_cmd_o/m_wdata_o = owner's slice;
//   cmd_ready_o[own] = m_cmd_ready_i & m_cmd_valid_o; handshake -> WAIT_RSP, watchdog cleared.
//  Only one outstanding command; non-owner cmd_ready_o always 0, their cmd_valid_i ignored.
//  WAIT_RSP: m_rsp_valid_i -> rsp_valid_o[own], rsp_code_o, rdata_o registered, 1-cycle latency; -> OWNED.
//   bus_open set on START with DONE; cleared on STOP DONE, any ARB_LOST, or ERR.
//  Release: in OWNED, req_i[own]=0 & !bus_open -> IDLE next cycle, grant_o=0, last_owner=own.
//   req_i[own]=0 & bus_open -> FORCE_STOP (owner abandoned open transfer).
//  Same-cycle req_i[own] drop with cmd_valid_i: command NOT accepted; release rule applies.
//  Watchdog: counts OWNED cycles with bus_open and no handshake; at TIMEOUT_CYC -> FORCE_STOP.
//   Saturates; never counts in IDLE, WAIT_RSP or with bus_open=0.
//  FORCE_STOP: grant_o=0, drive m_cmd_o=STOP,m_cmd_valid_o=1 until ready; FORCE_WAIT awaits m_rsp_valid_i,
//   response not forwarded; -> IDLE, bus_open=0, last_owner=own; timeout_o pulses only if watchdog caused it.
//  busy_o = (state != IDLE). m_cmd_valid_o held stable until m_cmd_ready_i (no retraction).
//  m_rsp_valid_i outside WAIT_RSP/FORCE_WAIT: ignored, flagged by assertion.
// TESTING
//  req_i=0101 from IDLE, last_owner=3 -> grant_o=0001 next cycle; r0 releases -> grant_o=0100 after IDLE.
//  r1 START,WRITE 0x44,RD_NAK(m_rdata_i=0xA5),STOP -> 4 rsp pulses on rsp_valid_o[1], rdata_o=0xA5; then release.
//  r2 START DONE, then silent TIMEOUT_CYC cycles -> m_cmd_o=STOP issued, timeout_o 1 pulse, grant_o=0.
//  r0 drops req_i after START -> forced STOP, no timeout_o, r3 granted next round.
//  rst_n_i low while WAIT_RSP -> all outputs 0 immediately; after release, fresh arbitration from r0.
//  WRITE rsp ARB_LOST -> rsp_code_o=2, bus_open=0; req_i drop then releases without STOP.

Source files
------------

// File: rtl/i2c_bus_scheduler.sv
// Round-robin sharing of one IICMB byte-command port among NUM_REQ requesters.
// Ownership spans whole START..STOP sessions; a watchdog forces STOP on stalled open buses.
module i2c_bus_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     cmd_valid_i,
    input  logic [3*NUM_REQ-1:0]   cmd_i,
    input  logic [8*NUM_REQ-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]     cmd_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    output logic [1:0]             rsp_code_o,
    output logic [7:0]             rdata_o,
    output logic                   m_cmd_valid_o,
    output logic [2:0]             m_cmd_o,
    output logic [7:0]             m_wdata_o,
    input  logic                   m_cmd_ready_i,
    input  logic                   m_rsp_valid_i,
    input  logic [1:0]             m_rsp_code_i,
    input  logic [7:0]             m_rdata_i,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] CMD_START    = 3'd0;
    localparam logic [2:0] CMD_STOP     = 3'd1;
    localparam logic [1:0] RSP_DONE     = 2'd0;
    localparam logic [1:0] RSP_ARB_LOST = 2'd2;
    localparam logic [1:0] RSP_ERR      = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_OWNED, S_WAIT_RSP, S_FORCE_STOP, S_FORCE_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d, last_q, last_d;
    logic              bus_open_q, bus_open_d;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic              wd_fired_q, wd_fired_d;
    logic [2:0]        sent_cmd_q, sent_cmd_d;
    logic [NUM_REQ-1:0] grant_d, rsp_valid_d;
    logic [1:0]        rsp_code_d;
    logic [7:0]        rdata_d;
    logic              busy_d, timeout_d;

    logic [2:0]        cmd_a   [NUM_REQ];
    logic [7:0]        wdata_a [NUM_REQ];
    logic [2:0]        own_cmd;
    logic [7:0]        own_wdata;
    logic              own_req, own_valid;
    logic [OW-1:0]     pick;
    logic              pick_found;
    int unsigned       idx;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_slice
        assign cmd_a[r]   = cmd_i[3*r +: 3];
        assign wdata_a[r] = wdata_i[8*r +: 8];
    end

    assign own_cmd   = cmd_a[owner_q];
    assign own_wdata = wdata_a[owner_q];
    assign own_req   = req_i[owner_q];
    assign own_valid = cmd_valid_i[owner_q];

    // Round-robin pick: first requester above last_owner, wrapping.
    always_comb begin
        pick       = last_q;
        pick_found = 1'b0;
        idx        = 0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            idx = (32'(last_q) + i) % NUM_REQ;
            if (req_i[OW'(idx)]) begin
                pick       = OW'(idx);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        bus_open_d    = bus_open_q;
        wdog_d        = wdog_q;
        wd_fired_d    = wd_fired_q;
        sent_cmd_d    = sent_cmd_q;
        grant_d       = grant_o;
        rsp_valid_d   = '0;
        rsp_code_d    = rsp_code_o;
        rdata_d       = rdata_o;
        timeout_d     = 1'b0;
        cmd_ready_o   = '0;
        m_cmd_valid_o = 1'b0;
        m_cmd_o       = '0;
        m_wdata_o     = '0;

        case (state_q)
            S_IDLE: begin
                wdog_d     = '0;
                wd_fired_d = 1'b0;
                if (pick_found) begin
                    owner_d = pick;
                    grant_d = onehot(pick);
                    state_d = S_OWNED;
                end
            end
            S_OWNED: begin
                m_cmd_valid_o = own_valid & own_req;
                m_cmd_o       = own_cmd;
                m_wdata_o     = own_wdata;
                if (!own_req) begin
                    grant_d = '0;
                    if (bus_open_q) begin
                        state_d = S_FORCE_STOP;
                    end else begin
                        state_d = S_IDLE;
                        last_d  = owner_q;
                    end
                end else if (m_cmd_valid_o && m_cmd_ready_i) begin
                    cmd_ready_o = onehot(owner_q);
                    sent_cmd_d  = own_cmd;
                    wdog_d      = '0;
                    state_d     = S_WAIT_RSP;
                end else if (bus_open_q) begin
                    if (wdog_q != WW'(TIMEOUT_CYC)) wdog_d = wdog_q + 1'b1;
                    if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
                        wd_fired_d = 1'b1;
                        grant_d    = '0;
                        state_d    = S_FORCE_STOP;
                    end
                end
            end
            S_WAIT_RSP: begin
                if (m_rsp_valid_i) begin
                    rsp_valid_d = onehot(owner_q);
                    rsp_code_d  = m_rsp_code_i;
                    rdata_d     = m_rdata_i;
                    state_d     = S_OWNED;
                    if (sent_cmd_q == CMD_START && m_rsp_code_i == RSP_DONE) bus_open_d = 1'b1;
                    if ((sent_cmd_q == CMD_STOP && m_rsp_code_i == RSP_DONE) ||
                        m_rsp_code_i == RSP_ARB_LOST || m_rsp_code_i == RSP_ERR) bus_open_d = 1'b0;
                end
            end
            S_FORCE_STOP: begin
                m_cmd_valid_o = 1'b1;
                m_cmd_o       = CMD_STOP;
                if (m_cmd_ready_i) state_d = S_FORCE_WAIT;
            end
            S_FORCE_WAIT: begin
                // Response belongs to the scheduler's own STOP; not forwarded.
                if (m_rsp_valid_i) begin
                    bus_open_d = 1'b0;
                    last_d     = owner_q;
                    timeout_d  = wd_fired_q;
                    wdog_d     = '0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            last_q      <= OW'(NUM_REQ - 1);
            bus_open_q  <= 1'b0;
            wdog_q      <= '0;
            wd_fired_q  <= 1'b0;
            sent_cmd_q  <= '0;
            grant_o     <= '0;
            rsp_valid_o <= '0;
            rsp_code_o  <= '0;
            rdata_o     <= '0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            bus_open_q  <= bus_open_d;
            wdog_q      <= wdog_d;
            wd_fired_q  <= wd_fired_d;
            sent_cmd_q  <= sent_cmd_d;
            grant_o     <= grant_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_code_o  <= rsp_code_d;
            rdata_o     <= rdata_d;
            busy_o      <= busy_d;
            timeout_o   <= timeout_d;
        end
    end

    // Adapter responses are only legal while a command is outstanding.
    rsp_in_window: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        m_rsp_valid_i |-> (state_q == S_WAIT_RSP || state_q == S_FORCE_WAIT));

endmodule
